// File: rtl/tdc_meas_sched.sv
// Round-robin scheduler sharing one TDC front-end between four request channels.
// Build macro TDC_MEAS_SCHED_STATS_EN adds saturating measurement/timeout counters.
module tdc_meas_sched #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GUARD_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    output logic [3:0]  ack,
    output logic        tdc_start,
    input  logic        tdc_done,
    input  logic [15:0] tdc_data,
    output logic [15:0] result,
    output logic [1:0]  result_ch,
    output logic        result_valid,
    output logic        timeout_err,
    output logic        busy,
    output logic [15:0] meas_cnt,
    output logic [7:0]  err_cnt,
    output logic [1:0]  state_dbg
);

    // Handshake: req[ch] is a level held by the requester until its one-cycle
    // ack[ch]; ack closes the transaction whether it succeeded or timed out.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRE  = 2'd1,
        WAIT  = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GUARD_LAST   = 8'(GUARD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  guard_q, guard_d;
    logic [1:0]  ch_q, ch_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  pick, idx;

    logic [3:0]  ack_d;
    logic        start_d, rv_d, to_err_d;
    logic [15:0] result_d;
    logic [1:0]  result_ch_d;

    assign state_dbg = state_q;

    // Scan from farthest to nearest so the channel right after ptr wins.
    always_comb begin
        pick = ptr_q;
        idx  = ptr_q;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr_q + 2'(i);
            if (req[idx]) pick = idx;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        guard_d     = guard_q;
        ch_d        = ch_q;
        ptr_d       = ptr_q;
        ack_d       = 4'b0000;
        start_d     = 1'b0;
        rv_d        = 1'b0;
        to_err_d    = 1'b0;
        result_d    = result;
        result_ch_d = result_ch;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    ch_d    = pick;
                    ptr_d   = pick;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                start_d = 1'b1;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 16'd1;
                if (tdc_done) begin
                    result_d    = tdc_data;
                    result_ch_d = ch_q;
                    rv_d        = 1'b1;
                    ack_d[ch_q] = 1'b1;
                    guard_d     = '0;
                    state_d     = GUARD;
                end else if (timer_q == TIMEOUT_LAST) begin
                    to_err_d    = 1'b1;
                    ack_d[ch_q] = 1'b1;
                    guard_d     = '0;
                    state_d     = GUARD;
                end
            end
            GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = IDLE;
                end else begin
                    guard_d = guard_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            guard_q      <= '0;
            ch_q         <= '0;
            ptr_q        <= 2'd3;
            ack          <= '0;
            tdc_start    <= 1'b0;
            result       <= '0;
            result_ch    <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            guard_q      <= guard_d;
            ch_q         <= ch_d;
            ptr_q        <= ptr_d;
            ack          <= ack_d;
            tdc_start    <= start_d;
            result       <= result_d;
            result_ch    <= result_ch_d;
            result_valid <= rv_d;
            timeout_err  <= to_err_d;
            busy         <= (state_d != IDLE);
        end
    end

`ifdef TDC_MEAS_SCHED_STATS_EN
    logic [15:0] meas_cnt_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meas_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (rv_d && (meas_cnt_q != 16'hFFFF)) meas_cnt_q <= meas_cnt_q + 16'd1;
            if (to_err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign meas_cnt = meas_cnt_q;
    assign err_cnt  = err_cnt_q;
`else
    assign meas_cnt = '0;
    assign err_cnt  = '0;
`endif

endmodule

// File: doc/tdc_meas_sched.md
TDC_MEAS_SCHED -- requirements
Module: tdc_meas_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max clk cycles in WAIT for tdc_done before abort (legal 2..65535).
REQ-002 Parameter GUARD_CYCLES, default 16, idle cycles after each measurement so the front-end edge detector and window counter fully re-arm (legal 1..255).
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  4  per-channel measurement request, level, held until ack.
REQ-006 ack  out  4  one-hot one-cycle pulse; measurement for that channel finished (success or timeout).
REQ-007 tdc_start  out  1  one-cycle pulse launching the shared TDC front-end.
REQ-008 tdc_done  in  1  one-cycle pulse from the TDC, tdc_data valid.
REQ-009 tdc_data  in  16  TDC fine/coarse result.
REQ-010 result  out  16  captured tdc_data, held until the next capture.
REQ-011 result_ch  out  2  channel that owns result.
REQ-012 result_valid  out  1  one-cycle pulse, result/result_ch updated.
REQ-013 timeout_err  out  1  one-cycle pulse, measurement aborted.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 meas_cnt  out  16  completed-measurement count (see Configuration).
REQ-016 err_cnt  out  8  timeout count (see Configuration).

Function
REQ-017 FSM states IDLE, FIRE, WAIT, GUARD; all outputs registered.
REQ-018 IDLE: if any req bit set, select channel by round-robin, searching upward from (last granted + 1) mod 4, then go to FIRE; otherwise stay.
REQ-019 Latency: req sampled high in IDLE on edge n -> tdc_start high for the cycle following edge n+1, exactly one cycle.
REQ-020 FIRE -> WAIT unconditionally; timer cleared to 0 on entry to WAIT.
REQ-021 WAIT: timer increments each cycle; tdc_done=1 -> capture tdc_data into result, selected channel into result_ch, pulse result_valid and ack[ch] on the next cycle, go GUARD.
REQ-022 WAIT: timer == TIMEOUT_CYCLES-1 with tdc_done=0 -> pulse timeout_err and ack[ch], result/result_ch unchanged, go GUARD.
REQ-023 tdc_done and timeout on the same cycle: tdc_done wins; no timeout_err.
REQ-024 tdc_done outside WAIT is ignored, no output changes.
REQ-025 req[ch] deasserted during FIRE/WAIT: measurement still completes and ack[ch] still pulses.
REQ-026 GUARD: stay exactly GUARD_CYCLES cycles, then IDLE; requests are not sampled.
REQ-027 Last-granted pointer updates at grant time, 2-bit, wraps 3 -> 0.
REQ-028 Back-to-back: all four req held -> grants 0,1,2,3,0... with no starvation.

Reset
REQ-029 reset_n low: state IDLE, timer 0, pointer 3 (first grant goes to channel 0), ack/tdc_start/result_valid/timeout_err/busy 0, result 0, result_ch 0, counters 0.
REQ-030 Reset mid-measurement aborts immediately; no ack or error pulse is produced afterward for that measurement.

Configuration
REQ-031 Macro TDC_MEAS_SCHED_STATS_EN defined: meas_cnt increments on each result_valid, err_cnt increments on each timeout_err, both saturating at all-ones.
REQ-032 Macro undefined: meas_cnt and err_cnt are constant 0, no counter logic is present; all other behaviour is identical.

Verification
REQ-033 Single req=4'b0100 held, tdc_done with tdc_data=16'h1234 three cycles after tdc_start -> result=16'h1234, result_ch=2, result_valid and ack=4'b0100 pulse once, busy low after 16 GUARD cycles.
REQ-034 req=4'b0001, no tdc_done, TIMEOUT_CYCLES=255 -> timeout_err and ack=4'b0001 255 cycles into WAIT, result unchanged, err_cnt=1 (STATS_EN).
REQ-035 req=4'b1111 held for 8 measurements -> grant order 0,1,2,3,0,1,2,3, exactly one tdc_start per measurement, consecutive tdc_start pulses at least GUARD_CYCLES+3 cycles apart.
REQ-036 tdc_done on the terminal timeout cycle -> result_valid pulses, timeout_err stays 0.
REQ-037 reset_n low during WAIT, then high -> all outputs 0, no ack or error pulse, next req=4'b0010 -> grant to channel 1.
REQ-038 Spurious tdc_done in IDLE and in GUARD -> no result_valid, result unchanged, meas_cnt unchanged.
